// File: rtl/fft32_mul_pkg.sv
// Shared definitions for the fft32 pipelined multiplier: operand mode encoding
// and the representable range of a result of a given width and signedness.
package fft32_mul_pkg;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   // Widest result whose limits range_limit can describe.
   localparam int LIM_W = 64;

   // Upper (upper=1) or lower (upper=0) bound of a width-bit result, as a bit pattern in the low width bits.
   function automatic logic [LIM_W-1:0] range_limit(input int width, input logic mode, input logic upper);
      logic [LIM_W-1:0] ones;
      ones = (width >= LIM_W) ? '1 : ((LIM_W'(1) << width) - LIM_W'(1));
      if (mode == MODE_SIGNED) begin
         if (upper) return ones >> 1;
         return ones & ~(ones >> 1);
      end
      if (upper) return ones;
      return '0;
   endfunction

endpackage

// File: rtl/fft32_mul_postproc.sv
// Combinational post-processing of an exact product: optional round-half-up,
// right shift, range check against the result width, and saturate or wrap.
module fft32_mul_postproc
   import fft32_mul_pkg::*;
#(
   parameter int P          = 37,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SAT        = 0,
   parameter int dout_WIDTH = 36
) (
   input  logic                  mode,
   input  logic [P-1:0]          prod,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   // One guard bit keeps the rounding add exact; X leaves room for the fit check whatever dout_WIDTH is.
   localparam int E   = P + 1;
   localparam int X   = ((E > dout_WIDTH) ? E : dout_WIDTH) + 1;
   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic [E-1:0]     RND   = (ROUND != 0 && SHIFT > 0) ? (E'(1) << RSH) : '0;
   localparam logic [LIM_W-1:0] MAX_U = range_limit(dout_WIDTH, MODE_UNSIGNED, 1'b1);
   localparam logic [LIM_W-1:0] MAX_S = range_limit(dout_WIDTH, MODE_SIGNED, 1'b1);
   localparam logic [LIM_W-1:0] MIN_S = range_limit(dout_WIDTH, MODE_SIGNED, 1'b0);

   logic [E-1:0] ext;
   logic [E-1:0] rnd;
   logic [E-1:0] shf;
   logic [X-1:0] wide;
   logic         fits;

   // NOTE: every variable below is assigned on all paths before any branch, so no latch can be inferred.
   always_comb begin
      ext = (mode == MODE_SIGNED) ? {prod[P-1], prod} : {1'b0, prod};
      rnd = ext + RND;
      // NOTE: the arithmetic shift stays out of a ?: with an unsigned arm, which would turn it logical.
      if (mode == MODE_SIGNED) shf = $signed(rnd) >>> SHIFT;
      else                     shf = rnd >> SHIFT;
      wide = (mode == MODE_SIGNED) ? {{(X-E){shf[E-1]}}, shf} : {{(X-E){1'b0}}, shf};

      if (mode == MODE_SIGNED) fits = (wide[X-1:dout_WIDTH-1] == '0) || (&wide[X-1:dout_WIDTH-1]);
      else                     fits = (wide[X-1:dout_WIDTH] == '0);

      ovf  = !fits;
      dout = wide[dout_WIDTH-1:0];
      if (SAT != 0 && !fits) begin
         if (mode == MODE_SIGNED) dout = wide[X-1] ? MIN_S[dout_WIDTH-1:0] : MAX_S[dout_WIDTH-1:0];
         else                     dout = MAX_U[dout_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fft32_mul_pipe.sv
// Pipelined integer multiplier for the fft32 datapath: exact product formed at
// accept, carried through NUM_STAGE valid/ready stages with bubble collapsing.
module fft32_mul_pipe
   import fft32_mul_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 22,
   parameter int dout_WIDTH = 36,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SAT        = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  signed_mode,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int P  = din0_WIDTH + din1_WIDTH + 1;
   localparam int PW = P + 1;

   if (NUM_STAGE < 1 || SHIFT < 0 || SHIFT >= din0_WIDTH + din1_WIDTH ||
       dout_WIDTH > LIM_W || ID < 0) begin : g_param_check
      $error("fft32_mul_pipe: illegal parameterisation");
   end

   logic [P-1:0] din0_ext;
   logic [P-1:0] din1_ext;
   logic [P-1:0] prod;

   // P bits hold any product of the two operands exactly, so a P-bit multiply needs no wider result.
   always_comb begin
      if (signed_mode == MODE_SIGNED) begin
         din0_ext = {{(P-din0_WIDTH){din0[din0_WIDTH-1]}}, din0};
         din1_ext = {{(P-din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
      end else begin
         din0_ext = {{(P-din0_WIDTH){1'b0}}, din0};
         din1_ext = {{(P-din1_WIDTH){1'b0}}, din1};
      end
      prod = din0_ext * din1_ext;
   end

   for (genvar k = 1; k <= NUM_STAGE; k++) begin : g_stage
      logic          v_q, v_d, up_v, adv;
      logic [PW-1:0] pl_q, pl_d, up_pl;

      if (k == 1) begin : g_head
         assign up_v  = in_valid;
         assign up_pl = {signed_mode, prod};
      end else begin : g_link
         assign up_v  = g_stage[k-1].v_q;
         assign up_pl = g_stage[k-1].pl_q;
      end

      // A stage moves when it is empty or its downstream neighbour moves.
      if (k == NUM_STAGE) begin : g_tail
         assign adv = !v_q || out_ready;
      end else begin : g_mid
         assign adv = !v_q || g_stage[k+1].adv;
      end

      always_comb begin
         v_d  = v_q;
         pl_d = pl_q;
         if (adv) begin
            v_d = up_v;
            if (up_v) pl_d = up_pl;
         end
      end

      // NOTE: payload is reset as well as valid, so dout and ovf read zero straight out of reset.
      always_ff @(posedge ap_clk or posedge ap_rst) begin
         if (ap_rst) begin
            v_q  <= 1'b0;
            pl_q <= '0;
         end else begin
            // NOTE: non-blocking updates let every stage sample its neighbour's pre-edge value.
            v_q  <= v_d;
            pl_q <= pl_d;
         end
      end
   end

   assign in_ready  = g_stage[1].adv && !ap_rst;
   assign out_valid = g_stage[NUM_STAGE].v_q;

   fft32_mul_postproc #(
      .P          (P),
      .SHIFT      (SHIFT),
      .ROUND      (ROUND),
      .SAT        (SAT),
      .dout_WIDTH (dout_WIDTH)
   ) u_postproc (
      .mode (g_stage[NUM_STAGE].pl_q[P]),
      .prod (g_stage[NUM_STAGE].pl_q[P-1:0]),
      .dout (dout),
      .ovf  (ovf)
   );

endmodule

// File: tb/tb_fft32_mul_pipe.sv
// Directed bench for fft32_mul_pipe: default instance plus a round/shift/saturate instance.
module tb_fft32_mul_pipe;

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   always #5 ap_clk = ~ap_clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge ap_clk) cyc = cyc + 1;

   logic        in_valid, in_ready, signed_mode, out_valid, out_ready, ovf;
   logic [13:0] din0;
   logic [21:0] din1;
   logic [35:0] dout;

   logic        in_valid2, in_ready2, signed_mode2, out_valid2, out_ready2, ovf2;
   logic [13:0] din0_2;
   logic [21:0] din1_2;
   logic [15:0] dout2;

   fft32_mul_pipe dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .signed_mode (signed_mode),
      .din0        (din0),
      .din1        (din1),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .dout        (dout),
      .ovf         (ovf)
   );

   fft32_mul_pipe #(
      .ID (2), .SHIFT (4), .ROUND (1), .SAT (1), .dout_WIDTH (16)
   ) dut_sat (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .in_valid    (in_valid2),
      .in_ready    (in_ready2),
      .signed_mode (signed_mode2),
      .din0        (din0_2),
      .din1        (din1_2),
      .out_valid   (out_valid2),
      .out_ready   (out_ready2),
      .dout        (dout2),
      .ovf         (ovf2)
   );

   // Transfers observed at the negative edge are those that happen at the following rising edge.
   int          acc_cyc [$];
   int          r_cyc   [$];
   logic [35:0] r_dout  [$];
   logic        r_ovf   [$];
   logic [15:0] r2_dout [$];
   logic        r2_ovf  [$];

   always @(negedge ap_clk) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc + 1);
      if (out_valid && out_ready) begin
         r_dout.push_back(dout);
         r_ovf.push_back(ovf);
         r_cyc.push_back(cyc + 1);
      end
      if (out_valid2 && out_ready2) begin
         r2_dout.push_back(dout2);
         r2_ovf.push_back(ovf2);
      end
   end

   task automatic clear_q();
      acc_cyc.delete(); r_cyc.delete(); r_dout.delete(); r_ovf.delete();
      r2_dout.delete(); r2_ovf.delete();
   endtask

   task automatic drive1(input logic v, input logic m, input logic [13:0] a, input logic [21:0] b,
                         input logic r);
      @(posedge ap_clk); #2;
      in_valid = v; signed_mode = m; din0 = a; din1 = b; out_ready = r;
      in_valid2 = 1'b0;
   endtask

   task automatic drive2(input logic v, input logic m, input logic [13:0] a, input logic [21:0] b);
      @(posedge ap_clk); #2;
      in_valid2 = v; signed_mode2 = m; din0_2 = a; din1_2 = b; out_ready2 = 1'b1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge ap_clk); #2;
         in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge ap_clk);
      #1;
      checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      checks++; if (dout !== 36'h0)     begin failures++; $display("FAIL rst_dout got=%h want=0", dout); end
      checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL rst_ovf got=%b want=0", ovf); end
      @(posedge ap_clk); #2;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_mode0();
      clear_q();
      drive1(1'b1, 1'b0, 14'h3FFF, 22'h3FFFFF, 1'b1);
      idle(6);
      checks++;
      if (r_dout.size() !== 1) begin failures++; $display("FAIL m0_count got=%0d want=1", r_dout.size()); end
      else begin
         checks++; if (r_dout[0] !== 36'hFFFBFC001) begin failures++; $display("FAIL m0_dout got=%h want=FFFBFC001", r_dout[0]); end
         checks++; if (r_ovf[0] !== 1'b0) begin failures++; $display("FAIL m0_ovf got=%b want=0", r_ovf[0]); end
         checks++;
         if (r_cyc[0] - acc_cyc[0] !== 3) begin failures++; $display("FAIL m0_latency got=%0d want=3", r_cyc[0] - acc_cyc[0]); end
      end
   endtask

   task automatic test_mode1();
      clear_q();
      drive1(1'b1, 1'b1, 14'h2000, 22'h3FFFFF, 1'b1);
      drive1(1'b1, 1'b1, 14'h2000, 22'h200000, 1'b1);
      idle(6);
      checks++;
      if (r_dout.size() !== 2) begin failures++; $display("FAIL m1_count got=%0d want=2", r_dout.size()); end
      else begin
         checks++; if (r_dout[0] !== 36'h000002000) begin failures++; $display("FAIL m1_neg_x_neg1 got=%h want=000002000", r_dout[0]); end
         checks++; if (r_ovf[0] !== 1'b0) begin failures++; $display("FAIL m1_ovf0 got=%b want=0", r_ovf[0]); end
         checks++; if (r_dout[1] !== 36'h400000000) begin failures++; $display("FAIL m1_min_x_min got=%h want=400000000", r_dout[1]); end
         checks++; if (r_ovf[1] !== 1'b0) begin failures++; $display("FAIL m1_ovf1 got=%b want=0", r_ovf[1]); end
         checks++;
         if (r_cyc[1] - r_cyc[0] !== 1) begin failures++; $display("FAIL m1_throughput got=%0d want=1", r_cyc[1] - r_cyc[0]); end
      end
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int held = -1;
      int low_cnt = 0;
      clear_q();
      for (int c = 0; c < 22; c++) begin
         @(posedge ap_clk); #2;
         in_valid    = (idx < 10);
         signed_mode = 1'b0;
         din0        = 14'(idx + 1);
         din1        = 22'h000100;
         out_ready   = !(c >= 2 && c <= 6);
         @(negedge ap_clk);
         if (!in_ready) begin
            low_cnt++;
            if (held < 0) held = idx;
         end
         if (in_valid && in_ready) idx++;
      end
      idle(1);
      checks++; if (held !== 3)    begin failures++; $display("FAIL bp_held got=%0d want=3", held); end
      checks++; if (low_cnt !== 4) begin failures++; $display("FAIL bp_ready_low_cycles got=%0d want=4", low_cnt); end
      checks++;
      if (r_dout.size() !== 10) begin failures++; $display("FAIL bp_count got=%0d want=10", r_dout.size()); end
      else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (r_dout[i] !== 36'((i + 1) * 256)) begin
               failures++; $display("FAIL bp_order[%0d] got=%h want=%h", i, r_dout[i], 36'((i + 1) * 256));
            end
            checks++;
            if (r_cyc[i] !== r_cyc[0] + i) begin
               failures++; $display("FAIL bp_one_per_cycle[%0d] got=%0d want=%0d", i, r_cyc[i], r_cyc[0] + i);
            end
         end
      end
   endtask

   task automatic test_bubbles();
      logic [35:0] exp_d [3];
      exp_d = '{36'h000000023, 36'h000100000, 36'h000012340};
      clear_q();
      drive1(1'b1, 1'b0, 14'h0005, 22'h000007, 1'b1);
      drive1(1'b0, 1'b0, 14'h0000, 22'h000000, 1'b1);
      drive1(1'b1, 1'b0, 14'h0100, 22'h001000, 1'b1);
      drive1(1'b1, 1'b0, 14'h1234, 22'h000010, 1'b1);
      idle(6);
      checks++;
      if (r_dout.size() !== 3 || acc_cyc.size() !== 3) begin
         failures++; $display("FAIL bub_count got=%0d/%0d want=3/3", acc_cyc.size(), r_dout.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_dout[i] !== exp_d[i]) begin failures++; $display("FAIL bub_dout[%0d] got=%h want=%h", i, r_dout[i], exp_d[i]); end
            checks++;
            if (r_cyc[i] !== acc_cyc[i] + 3) begin
               failures++; $display("FAIL bub_latency[%0d] got=%0d want=%0d", i, r_cyc[i], acc_cyc[i] + 3);
            end
         end
         checks++;
         if (r_cyc[1] - r_cyc[0] !== 2) begin failures++; $display("FAIL bub_gap got=%0d want=2", r_cyc[1] - r_cyc[0]); end
      end
   endtask

   task automatic test_sat_round();
      logic [15:0] exp_d [4];
      logic        exp_o [4];
      exp_d = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'hFFFF};
      exp_o = '{1'b0, 1'b0, 1'b1, 1'b1};
      clear_q();
      drive2(1'b1, 1'b1, 14'h0003, 22'h000003);
      drive2(1'b1, 1'b1, 14'h3FFD, 22'h000003);
      drive2(1'b1, 1'b1, 14'h1FFF, 22'h1FFFFF);
      drive2(1'b1, 1'b0, 14'h1FFF, 22'h1FFFFF);
      idle(6);
      checks++;
      if (r2_dout.size() !== 4) begin failures++; $display("FAIL sat_count got=%0d want=4", r2_dout.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (r2_dout[i] !== exp_d[i]) begin failures++; $display("FAIL sat_dout[%0d] got=%h want=%h", i, r2_dout[i], exp_d[i]); end
            checks++;
            if (r2_ovf[i] !== exp_o[i]) begin failures++; $display("FAIL sat_ovf[%0d] got=%b want=%b", i, r2_ovf[i], exp_o[i]); end
         end
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 3; i++) drive1(1'b1, 1'b0, 14'(i + 1), 22'h000010, 1'b0);
      drive1(1'b0, 1'b0, 14'h0000, 22'h000000, 1'b0);
      @(negedge ap_clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         failures++; $display("FAIL mid_full_stall got=%b%b want=10", out_valid, in_ready);
      end
      #2;
      ap_rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
      checks++; if (dout !== 36'h0)     begin failures++; $display("FAIL mid_rst_dout got=%h want=0", dout); end
      checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL mid_rst_ovf got=%b want=0", ovf); end
      checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready); end
      @(posedge ap_clk); #2;
      ap_rst = 1'b0;
      clear_q();
      drive1(1'b1, 1'b0, 14'h0007, 22'h000009, 1'b1);
      idle(6);
      checks++;
      if (r_dout.size() !== 1) begin failures++; $display("FAIL mid_after_count got=%0d want=1", r_dout.size()); end
      else begin
         checks++; if (r_dout[0] !== 36'd63) begin failures++; $display("FAIL mid_after_dout got=%h want=3f", r_dout[0]); end
         checks++;
         if (r_cyc[0] - acc_cyc[0] !== 3) begin failures++; $display("FAIL mid_after_latency got=%0d want=3", r_cyc[0] - acc_cyc[0]); end
      end
   endtask

   initial begin
      in_valid  = 1'b0; signed_mode  = 1'b0; din0   = '0; din1   = '0; out_ready  = 1'b1;
      in_valid2 = 1'b0; signed_mode2 = 1'b0; din0_2 = '0; din1_2 = '0; out_ready2 = 1'b1;
      test_reset();
      test_mode0();
      test_mode1();
      test_backpressure();
      test_bubbles();
      test_sat_round();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout sim_time=%0t limit=200000", $time);
      $fatal(1, "bench time limit expired");
   end

endmodule
